// File: rtl/bus_txn_controller.sv
// bus_txn_controller: three-master bus arbiter and transaction sequencer with timeout and unmapped-address error.
// Defining BUS_FIXED_PRIORITY_EN selects fixed M1>M2>M3 priority instead of round-robin.
module bus_txn_controller #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      req,
  input  logic [3*AW-1:0] m_addr,
  input  logic [3*DW-1:0] m_wdata,
  input  logic [2:0]      m_we,
  output logic [2:0]      ack,
  output logic [AW-1:0]   bus_addr,
  output logic [DW-1:0]   bus_wdata,
  output logic            bus_we,
  output logic            bus_valid,
  output logic [2:0]      sel,
  input  logic [2:0]      s_ready,
  input  logic [3*DW-1:0] s_rdata,
  output logic [DW-1:0]   m_rdata,
  output logic            done,
  output logic            err
);
  typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;
  state_t state;
  logic [1:0] last, widx, slv;
  logic [7:0] cnt;
  logic rdy;
  assign slv = bus_addr[AW-1:AW-2];
  assign rdy = |(s_ready & sel);
`ifdef BUS_FIXED_PRIORITY_EN
  always_comb widx = req[0] ? 2'd0 : req[1] ? 2'd1 : 2'd2;
`else
  logic [1:0] n1, n2;
  // search order starts just after the previous winner and wraps
  always_comb begin
    n1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
    n2 = (n1 == 2'd2) ? 2'd0 : n1 + 2'd1;
    widx = req[n1] ? n1 : req[n2] ? n2 : last;
  end
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ack       <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_we    <= 1'b0;
      bus_valid <= 1'b0;
      sel       <= '0;
      m_rdata   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
      last      <= 2'd2;
    end else begin
      case (state)
        IDLE: if (|req) begin
          ack       <= 3'b001 << widx;
          bus_addr  <= m_addr[AW*widx +: AW];
          bus_wdata <= m_wdata[DW*widx +: DW];
          bus_we    <= m_we[widx];
          state     <= ADDR;
        end
        ADDR: if (slv == 2'b11) begin
          err   <= 1'b1;
          done  <= 1'b1;
          state <= DONE;
        end else begin
          sel       <= 3'b001 << slv;
          bus_valid <= 1'b1;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: if (rdy || cnt == 8'(TIMEOUT - 1)) begin
          if (rdy && !bus_we) m_rdata <= s_rdata[DW*slv +: DW];
          err       <= !rdy;
          done      <= 1'b1;
          bus_valid <= 1'b0;
          sel       <= '0;
          state     <= DONE;
        end else cnt <= cnt + 8'd1;
        default: begin
          done  <= 1'b0;
          err   <= 1'b0;
          ack   <= '0;
          last  <= ack[0] ? 2'd0 : ack[1] ? 2'd1 : 2'd2;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_txn_controller.sv
// tb_bus_txn_controller: directed vectors for bus_txn_controller with hand-computed expectations.
module tb_bus_txn_controller;
  logic clk = 1'b0;
  logic reset;
  logic [2:0] req, m_we, s_ready, ack, sel;
  logic [23:0] m_addr, m_wdata, s_rdata;
  logic [7:0] bus_addr, bus_wdata, m_rdata;
  logic bus_we, bus_valid, done, err;
  logic [33:0] outs;
  logic [2:0] exp_ack [4];
  int checks = 0;
  int failures = 0;
  int n;

  bus_txn_controller dut (
    .clk(clk), .reset(reset), .req(req), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
    .ack(ack), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_valid(bus_valid),
    .sel(sel), .s_ready(s_ready), .s_rdata(s_rdata), .m_rdata(m_rdata), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  assign outs = {ack, bus_addr, bus_wdata, bus_we, bus_valid, sel, m_rdata, done, err};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
`ifdef BUS_FIXED_PRIORITY_EN
    exp_ack = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
    exp_ack = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
    reset = 1'b1; req = '0; m_we = '0; s_ready = '0; m_addr = '0; m_wdata = '0; s_rdata = '0;
    tick(); tick();
    chk("reset_outs", 64'(outs), 64'd0);
    reset = 1'b0;
    // single read from S0 with zero-wait ready
    req = 3'b001; m_addr[7:0] = 8'h12; s_rdata[7:0] = 8'hA5; s_ready = 3'b001;
    tick();
    chk("t1_ack", 64'(ack), 64'h1);
    chk("t1_addr", 64'(bus_addr), 64'h12);
    chk("t1_valid_addr", 64'(bus_valid), 64'h0);
    req = '0;
    tick();
    chk("t1_sel", 64'(sel), 64'h1);
    chk("t1_valid", 64'(bus_valid), 64'h1);
    chk("t1_done_early", 64'(done), 64'h0);
    tick();
    chk("t1_done", 64'(done), 64'h1);
    chk("t1_err", 64'(err), 64'h0);
    chk("t1_rdata", 64'(m_rdata), 64'hA5);
    chk("t1_valid_done", 64'(bus_valid), 64'h0);
    tick();
    chk("t1_ack_clr", 64'(ack), 64'h0);
    chk("t1_done_clr", 64'(done), 64'h0);
    // held requests from all masters after a fresh reset
    reset = 1'b1; tick(); reset = 1'b0;
    m_addr = {8'h03, 8'h02, 8'h01}; s_rdata[7:0] = 8'h5A; req = 3'b111; s_ready = 3'b001;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_ack", 64'(ack), 64'(exp_ack[i]));
      tick(); tick();
      chk("t2_done", 64'(done), 64'h1);
      tick();
      chk("t2_gap", 64'(ack), 64'h0);
    end
    req = '0;
    // M2 write to S2
    req = 3'b010; m_addr[15:8] = 8'h80; m_wdata[15:8] = 8'h3C; m_we = 3'b010;
    s_ready = 3'b100; s_rdata[23:16] = 8'hFF;
    tick();
    chk("t3_ack", 64'(ack), 64'h2);
    chk("t3_we", 64'(bus_we), 64'h1);
    chk("t3_wdata", 64'(bus_wdata), 64'h3C);
    req = '0;
    tick();
    chk("t3_sel", 64'(sel), 64'h4);
    tick();
    chk("t3_done", 64'(done), 64'h1);
    chk("t3_rdata_kept", 64'(m_rdata), 64'h5A);
    tick();
    m_we = '0;
    // M3 unmapped access
    req = 3'b100; m_addr[23:16] = 8'hC0;
    tick();
    chk("t4_ack", 64'(ack), 64'h4);
    chk("t4_valid_addr", 64'(bus_valid), 64'h0);
    req = '0;
    tick();
    chk("t4_done_err", 64'({done, err, bus_valid, sel}), 64'({1'b1, 1'b1, 1'b0, 3'b000}));
    tick();
    chk("t4_clr", 64'({ack, done, err}), 64'h0);
    // S1 timeout; unselected readies must be ignored
    req = 3'b001; m_addr[7:0] = 8'h40; s_ready = 3'b101; s_rdata[15:8] = 8'h99;
    tick();
    req = '0;
    tick();
    chk("t5_sel", 64'({sel, bus_valid}), 64'({3'b010, 1'b1}));
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    chk("t5_wait_cycles", 64'(n), 64'd15);
    chk("t5_err", 64'(err), 64'h1);
    chk("t5_valid_off", 64'({bus_valid, sel}), 64'h0);
    chk("t5_rdata_kept", 64'(m_rdata), 64'h5A);
    tick();
    chk("t5_ack_clr", 64'(ack), 64'h0);
    // ready arriving in the last allowed WAIT cycle wins over timeout
    req = 3'b001; s_ready = '0;
    tick();
    req = '0;
    tick();
    repeat (14) tick();
    chk("t6_no_done", 64'(done), 64'h0);
    s_ready = 3'b010;
    tick();
    chk("t6_done", 64'({done, err}), 64'({1'b1, 1'b0}));
    chk("t6_rdata", 64'(m_rdata), 64'h99);
    s_ready = '0;
    tick();
    // reset while in WAIT, then a normal grant
    req = 3'b001;
    tick();
    req = '0;
    tick();
    chk("t7_in_wait", 64'(bus_valid), 64'h1);
    reset = 1'b1;
    #1 chk("t7_reset_async", 64'(outs), 64'd0);
    tick();
    chk("t7_reset_hold", 64'(outs), 64'd0);
    reset = 1'b0;
    req = 3'b010; m_addr[15:8] = 8'h01; s_rdata[7:0] = 8'h77; s_ready = 3'b001;
    tick();
    chk("t7_ack", 64'(ack), 64'h2);
    req = '0;
    tick(); tick();
    chk("t7_done", 64'(done), 64'h1);
    chk("t7_rdata", 64'(m_rdata), 64'h77);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
